// File: rtl/countdown_timer_pkg.sv
// Shared types and helpers for the countdown timer: state encoding, tick sizing,
// and preset wrap arithmetic.
package countdown_timer_pkg;

  localparam int unsigned DEFAULT_CLK_FREQ = 50_000_000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int unsigned tick_cycles(input int unsigned clk_freq);
    return clk_freq / 10;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Preset step with wrap; 8-bit sum so preset+10 cannot overflow before the modulo.
  function automatic logic [6:0] preset_add(input logic [6:0] preset,
                                            input logic [7:0] inc,
                                            input logic [7:0] modulus);
    logic [7:0] sum;
    sum = (8'(preset) + inc) % modulus;
    return sum[6:0];
  endfunction

endpackage

// File: rtl/countdown_timer_tick_gen.sv
// Decisecond prescaler: counts while enabled, holds otherwise, clears on demand.
module countdown_timer_tick_gen
  import countdown_timer_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned PRE_W = cnt_width(TICK_CYCLES);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);

  logic [PRE_W-1:0] r_pre;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_pre <= '0;
    end else if (enable) begin
      r_pre <= (r_pre == PRE_LAST) ? '0 : r_pre + PRE_W'(1);
    end
  end

  assign tick = enable && (r_pre == PRE_LAST);

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer: preset entry, run/pause decisecond countdown to 0.0, and a
// timed alarm that auto-returns to IDLE.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = DEFAULT_CLK_FREQ,
  parameter int unsigned MAX_SEC    = 99,
  parameter int unsigned ALARM_DSEC = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       add1_pulse,
  input  logic       add10_pulse,
  input  logic       start_stop_pulse,
  input  logic       clear_pulse,
  output logic [6:0] sec,
  output logic [3:0] dsec,
  output logic       running,
  output logic       alarm
);

  localparam int unsigned TICK_CYC = tick_cycles(CLK_FREQ);
  localparam int unsigned ACNT_W   = cnt_width(ALARM_DSEC + 1);
  localparam logic [7:0]  PRESET_MOD = 8'(MAX_SEC + 1);
  localparam logic [ACNT_W-1:0] ALARM_LAST = ACNT_W'(ALARM_DSEC - 1);

  state_t            r_state, w_state_nxt;
  logic [6:0]        r_preset, w_preset_nxt;
  logic [6:0]        r_cnt_sec, w_cnt_sec_nxt;
  logic [3:0]        r_cnt_dsec, w_cnt_dsec_nxt;
  logic [ACNT_W-1:0] r_alarm_cnt, w_alarm_cnt_nxt;
  logic [6:0]        r_sec, w_sec_nxt;
  logic [3:0]        r_dsec, w_dsec_nxt;
  logic              r_running, r_alarm;
  logic              w_tick_en, w_tick_clr, w_tick, w_any_pulse;

  assign w_any_pulse = add1_pulse | add10_pulse | start_stop_pulse | clear_pulse;

  countdown_timer_tick_gen #(
    .TICK_CYCLES(TICK_CYC)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .enable (w_tick_en),
    .clear  (w_tick_clr),
    .tick   (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_preset    <= '0;
      r_cnt_sec   <= '0;
      r_cnt_dsec  <= '0;
      r_alarm_cnt <= '0;
      r_sec       <= '0;
      r_dsec      <= '0;
      r_running   <= 1'b0;
      r_alarm     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_preset    <= w_preset_nxt;
      r_cnt_sec   <= w_cnt_sec_nxt;
      r_cnt_dsec  <= w_cnt_dsec_nxt;
      r_alarm_cnt <= w_alarm_cnt_nxt;
      r_sec       <= w_sec_nxt;
      r_dsec      <= w_dsec_nxt;
      r_running   <= (w_state_nxt == ST_RUN);
      r_alarm     <= (w_state_nxt == ST_DONE);
    end
  end

  // Next state, counters and display; priority clear > start_stop > add10 > add1.
  always_comb begin
    w_state_nxt     = r_state;
    w_preset_nxt    = r_preset;
    w_cnt_sec_nxt   = r_cnt_sec;
    w_cnt_dsec_nxt  = r_cnt_dsec;
    w_alarm_cnt_nxt = r_alarm_cnt;
    w_tick_en       = 1'b0;
    w_tick_clr      = 1'b0;
    w_sec_nxt       = '0;
    w_dsec_nxt      = '0;

    case (r_state)
      ST_IDLE: begin
        if (clear_pulse) begin
          w_preset_nxt = '0;
        end else if (start_stop_pulse) begin
          if (r_preset != 7'd0) begin
            w_state_nxt    = ST_RUN;
            w_cnt_sec_nxt  = r_preset;
            w_cnt_dsec_nxt = 4'd0;
            w_tick_clr     = 1'b1;
          end
        end else if (add10_pulse) begin
          w_preset_nxt = preset_add(r_preset, 8'd10, PRESET_MOD);
        end else if (add1_pulse) begin
          w_preset_nxt = preset_add(r_preset, 8'd1, PRESET_MOD);
        end
      end

      ST_RUN: begin
        if (clear_pulse) begin
          w_state_nxt = ST_IDLE;
        end else if (start_stop_pulse) begin
          w_state_nxt = ST_PAUSE;
        end else begin
          w_tick_en = 1'b1;
          if (w_tick) begin
            if (r_cnt_dsec != 4'd0) begin
              w_cnt_dsec_nxt = r_cnt_dsec - 4'd1;
            end else begin
              w_cnt_sec_nxt  = r_cnt_sec - 7'd1;
              w_cnt_dsec_nxt = 4'd9;
            end
            if (r_cnt_sec == 7'd0 && r_cnt_dsec == 4'd1) begin
              w_state_nxt     = ST_DONE;
              w_alarm_cnt_nxt = '0;
            end
          end
        end
      end

      ST_PAUSE: begin
        if (clear_pulse) begin
          w_state_nxt = ST_IDLE;
        end else if (start_stop_pulse) begin
          w_state_nxt = ST_RUN;
        end
      end

      ST_DONE: begin
        w_tick_en = 1'b1;
        if (w_any_pulse) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tick) begin
          if (r_alarm_cnt == ALARM_LAST) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_alarm_cnt_nxt = r_alarm_cnt + ACNT_W'(1);
          end
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase

    case (w_state_nxt)
      ST_IDLE: begin
        w_sec_nxt  = w_preset_nxt;
        w_dsec_nxt = 4'd0;
      end
      ST_RUN, ST_PAUSE: begin
        w_sec_nxt  = w_cnt_sec_nxt;
        w_dsec_nxt = w_cnt_dsec_nxt;
      end
      default: begin
        w_sec_nxt  = '0;
        w_dsec_nxt = '0;
      end
    endcase
  end

  assign sec     = r_sec;
  assign dsec    = r_dsec;
  assign running = r_running;
  assign alarm   = r_alarm;

endmodule
